// File: rtl/qspi_shift_engine.sv
// qspi_shift_engine: QSPI TX serialiser / RX deserialiser over 1, 2 or 4 IO lanes.
// MODE_ZERO counts dummy cycles without touching the pads or the RX word.
module qspi_shift_engine #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              dir_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              shift_tick_i,
    input  logic [3:0]        io_in_i,
    output logic [3:0]        io_out_o,
    output logic [3:0]        io_oe_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [2:0]        lane_w_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_DUAL   = 2'd2;
    localparam logic [1:0] MODE_QUAD   = 2'd3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [2:0]        lane_q, lane_d;
    logic [LEN_W-1:0]  ticks_q, ticks_d;

    logic [LEN_W-1:0]  len_c, ticks_n;
    logic [2:0]        lane_n;
    logic              shifting;

    assign len_c   = (len_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len_i;
    assign lane_n  = (mode_i == MODE_ZERO)   ? 3'd0 :
                     (mode_i == MODE_SINGLE) ? 3'd1 :
                     (mode_i == MODE_DUAL)   ? 3'd2 : 3'd4;
    // Dummy cycles are not clamped; data modes round up to whole lane groups.
    assign ticks_n = (mode_i == MODE_ZERO)   ? len_i :
                     (mode_i == MODE_SINGLE) ? len_c :
                     (mode_i == MODE_DUAL)   ? (len_c + LEN_W'(1)) >> 1 :
                                               (len_c + LEN_W'(3)) >> 2;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        lane_d  = lane_q;
        ticks_d = ticks_q;
        if (state_q == IDLE && start_i) begin
            mode_d  = mode_i;
            dir_d   = dir_i;
            tx_d    = tx_data_i;
            rx_d    = '0;
            lane_d  = lane_n;
            ticks_d = ticks_n;
            state_d = (ticks_n == '0) ? DONE : SHIFT;
        end else if (state_q == SHIFT && shift_tick_i) begin
            rx_d    = (mode_q == MODE_SINGLE) ? {rx_q[DATA_W-2:0], io_in_i[1]} :
                      (mode_q == MODE_DUAL)   ? {rx_q[DATA_W-3:0], io_in_i[1:0]} :
                      (mode_q == MODE_QUAD)   ? {rx_q[DATA_W-5:0], io_in_i} : rx_q;
            tx_d    = tx_q << lane_q;
            ticks_d = ticks_q - LEN_W'(1);
            state_d = (ticks_q == LEN_W'(1)) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mode_q  <= MODE_ZERO;
            dir_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            lane_q  <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            lane_q  <= lane_d;
            ticks_q <= ticks_d;
        end
    end

    assign shifting  = (state_q == SHIFT);
    assign io_out_o  = !shifting                 ? 4'b0000 :
                       (mode_q == MODE_SINGLE)   ? {3'b000, tx_q[DATA_W-1]} :
                       (mode_q == MODE_DUAL)     ? {2'b00, tx_q[DATA_W-1 -: 2]} :
                       (mode_q == MODE_QUAD)     ? tx_q[DATA_W-1 -: 4] : 4'b0000;
    assign io_oe_o   = !shifting                         ? 4'b0000 :
                       (mode_q == MODE_SINGLE)           ? 4'b0001 :
                       (mode_q == MODE_DUAL && !dir_q)   ? 4'b0011 :
                       (mode_q == MODE_QUAD && !dir_q)   ? 4'b1111 : 4'b0000;
    assign rx_data_o = rx_q;
    assign lane_w_o  = lane_q;
    assign busy_o    = shifting;
    assign done_o    = (state_q == DONE);
endmodule
